// File: rtl/steuerung_pkg.sv
// Shared definitions for the sequencer: parameter defaults, one-hot state codes
// and the index-width helper used for the interrupt number port.
package steuerung_pkg;

  localparam int DEKODIER_ZYKLEN_STD = 2;
  localparam int TIMEOUT_ZYKLEN_STD  = 64;
  localparam int IRQ_ANZAHL_STD      = 4;
  localparam int ZAEHLER_BREITE_STD  = 32;

  typedef enum logic [10:0] {
    S_FETCH      = 11'b000_0000_0001,
    S_DECODE     = 11'b000_0000_0010,
    S_ALUSTART   = 11'b000_0000_0100,
    S_ALU        = 11'b000_0000_1000,
    S_WB_JUMP    = 11'b000_0001_0000,
    S_WB_STORE   = 11'b000_0010_0000,
    S_WB_LOAD    = 11'b000_0100_0000,
    S_WB_DEFAULT = 11'b000_1000_0000,
    S_IRQ_ENTRY  = 11'b001_0000_0000,
    S_HALT       = 11'b010_0000_0000,
    S_FAULT      = 11'b100_0000_0000
  } zustand_t;

  // A single interrupt line still gets a one-bit index port.
  function automatic int index_breite(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/steuerung_v2_interrupt_prioritaet.sv
// Picks the lowest-numbered active line out of the already masked request vector.
module interrupt_prioritaet
  import steuerung_pkg::*;
#(
  parameter int ANZAHL = IRQ_ANZAHL_STD
) (
  input  logic [ANZAHL-1:0]               anfrage,
  output logic                            gueltig,
  output logic [index_breite(ANZAHL)-1:0] nummer
);

  localparam int IW = index_breite(ANZAHL);

  // Scanning downwards lets the lowest set index overwrite all higher ones.
  always_comb begin
    nummer = '0;
    for (int i = ANZAHL - 1; i >= 0; i--) begin
      if (anfrage[i]) begin
        nummer = IW'(i);
      end
    end
  end

  assign gueltig = |anfrage;

endmodule

// File: rtl/steuerung_v2.sv
// Multi-cycle instruction sequencer: fetch/decode/ALU/writeback handshakes,
// level interrupts with a single nesting level, halt, and a bus-wait timeout.
module steuerung_v2
  import steuerung_pkg::*;
#(
  parameter int DEKODIER_ZYKLEN = DEKODIER_ZYKLEN_STD,
  parameter int TIMEOUT_ZYKLEN  = TIMEOUT_ZYKLEN_STD,
  parameter int IRQ_ANZAHL      = IRQ_ANZAHL_STD,
  parameter int ZAEHLER_BREITE  = ZAEHLER_BREITE_STD
) (
  input  logic                                Clock,
  input  logic                                Reset,
  input  logic                                BefehlGeladen,
  input  logic                                DatenGeladen,
  input  logic                                DatenGespeichert,
  input  logic                                ALUFertig,
  input  logic                                LoadBefehl,
  input  logic                                StoreBefehl,
  input  logic                                JALBefehl,
  input  logic                                UnbedingterSprungBefehl,
  input  logic                                BedingterSprungBefehl,
  input  logic                                Bedingung,
  input  logic                                HaltBefehl,
  input  logic                                RueckkehrBefehl,
  input  logic [IRQ_ANZAHL-1:0]               InterruptAnfrage,
  input  logic [IRQ_ANZAHL-1:0]               InterruptMaske,
  output logic                                LoadBefehlSignal,
  output logic                                DekodierSignal,
  output logic                                ALUStartSignal,
  output logic                                RegisterSchreibSignal,
  output logic                                LoadDatenSignal,
  output logic                                StoreDatenSignal,
  output logic                                PCSignal,
  output logic                                PCSprungSignal,
  output logic                                InterruptEintrittSignal,
  output logic                                InterruptAktiv,
  output logic                                Angehalten,
  output logic                                BusFehler,
  output logic [index_breite(IRQ_ANZAHL)-1:0] InterruptNummer,
  output logic [ZAEHLER_BREITE-1:0]           Befehlszaehler
);

  localparam int WART_BREITE = $clog2(TIMEOUT_ZYKLEN + 2);

  zustand_t                          state_reg, state_next;
  logic [WART_BREITE-1:0]            wart_reg, wart_next;
  logic [3:0]                        dek_reg, dek_next;
  logic                              irq_aktiv_reg, irq_aktiv_next;
  logic [ZAEHLER_BREITE-1:0]         zaehler_reg, zaehler_next;

  logic                              irq_gueltig;
  logic [index_breite(IRQ_ANZAHL)-1:0] irq_nummer;
  logic                              zeit_ab;
  logic                              dek_fertig;
  logic                              sprung;
  zustand_t                          grenze_ziel;

  interrupt_prioritaet #(
    .ANZAHL (IRQ_ANZAHL)
  ) u_prio (
    .anfrage (InterruptAnfrage & InterruptMaske),
    .gueltig (irq_gueltig),
    .nummer  (irq_nummer)
  );

  assign zeit_ab     = (TIMEOUT_ZYKLEN != 0) && (wart_reg == WART_BREITE'(TIMEOUT_ZYKLEN - 1));
  assign dek_fertig  = (dek_reg == 4'(DEKODIER_ZYKLEN - 1));
  assign sprung      = UnbedingterSprungBefehl | BedingterSprungBefehl;
  // The boundary decision looks at the registered flag, so a return jump
  // clearing it cannot also take an interrupt in the same cycle.
  assign grenze_ziel = (!irq_aktiv_reg && irq_gueltig) ? S_IRQ_ENTRY : S_FETCH;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_reg     <= S_FETCH;
      wart_reg      <= '0;
      dek_reg       <= '0;
      irq_aktiv_reg <= 1'b0;
      zaehler_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      wart_reg      <= wart_next;
      dek_reg       <= dek_next;
      irq_aktiv_reg <= irq_aktiv_next;
      zaehler_reg   <= zaehler_next;
    end
  end

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH: begin
        if (BefehlGeladen)  state_next = S_DECODE;
        else if (zeit_ab)   state_next = S_FAULT;
        else                state_next = S_FETCH;
      end
      S_DECODE:   state_next = dek_fertig ? S_ALUSTART : S_DECODE;
      S_ALUSTART: state_next = S_ALU;
      S_ALU: begin
        if (!ALUFertig)       state_next = S_ALU;
        else if (HaltBefehl)  state_next = S_HALT;
        else if (sprung)      state_next = S_WB_JUMP;
        else if (StoreBefehl) state_next = S_WB_STORE;
        else if (LoadBefehl)  state_next = S_WB_LOAD;
        else                  state_next = S_WB_DEFAULT;
      end
      S_WB_JUMP:    state_next = grenze_ziel;
      S_WB_DEFAULT: state_next = grenze_ziel;
      S_WB_STORE: begin
        if (DatenGespeichert) state_next = grenze_ziel;
        else if (zeit_ab)     state_next = S_FAULT;
        else                  state_next = S_WB_STORE;
      end
      S_WB_LOAD: begin
        if (DatenGeladen)     state_next = S_WB_DEFAULT;
        else if (zeit_ab)     state_next = S_FAULT;
        else                  state_next = S_WB_LOAD;
      end
      S_IRQ_ENTRY: state_next = S_FETCH;
      S_HALT:      state_next = irq_gueltig ? S_IRQ_ENTRY : S_HALT;
      S_FAULT:     state_next = S_FAULT;
      default:     state_next = S_FETCH;
    endcase
  end

  always_comb begin
    LoadBefehlSignal        = 1'b0;
    DekodierSignal          = 1'b0;
    ALUStartSignal          = 1'b0;
    RegisterSchreibSignal   = 1'b0;
    LoadDatenSignal         = 1'b0;
    StoreDatenSignal        = 1'b0;
    PCSignal                = 1'b0;
    PCSprungSignal          = UnbedingterSprungBefehl | (BedingterSprungBefehl & Bedingung);
    InterruptEintrittSignal = 1'b0;
    Angehalten              = 1'b0;
    BusFehler               = 1'b0;
    InterruptNummer         = '0;
    case (state_reg)
      S_FETCH:      LoadBefehlSignal = 1'b1;
      S_DECODE:     DekodierSignal   = 1'b1;
      S_ALUSTART: begin
        ALUStartSignal        = 1'b1;
        RegisterSchreibSignal = JALBefehl;
      end
      S_ALU:        RegisterSchreibSignal = JALBefehl;
      S_WB_JUMP:    PCSignal = 1'b1;
      S_WB_STORE: begin
        StoreDatenSignal = 1'b1;
        PCSignal         = DatenGespeichert;
      end
      S_WB_LOAD:    LoadDatenSignal = 1'b1;
      S_WB_DEFAULT: begin
        RegisterSchreibSignal = 1'b1;
        PCSignal              = 1'b1;
      end
      S_IRQ_ENTRY: begin
        InterruptEintrittSignal = 1'b1;
        InterruptNummer         = irq_nummer;
      end
      S_HALT: begin
        Angehalten = 1'b1;
        PCSignal   = irq_gueltig;
      end
      S_FAULT: begin
        BusFehler      = 1'b1;
        PCSprungSignal = 1'b0;
      end
      default: PCSprungSignal = 1'b0;
    endcase
  end

  always_comb begin
    // Counters restart whenever the state changes; the wait counter only
    // advances in states that block on an external handshake.
    if (state_next != state_reg) begin
      wart_next = '0;
      dek_next  = '0;
    end else begin
      wart_next = wart_reg;
      dek_next  = dek_reg;
      if (state_reg == S_FETCH || state_reg == S_WB_LOAD || state_reg == S_WB_STORE) begin
        wart_next = wart_reg + 1'b1;
      end
      if (state_reg == S_DECODE) begin
        dek_next = dek_reg + 1'b1;
      end
    end

    irq_aktiv_next = irq_aktiv_reg;
    if (state_reg == S_IRQ_ENTRY) begin
      irq_aktiv_next = 1'b1;
    end else if (state_reg == S_WB_JUMP && RueckkehrBefehl) begin
      irq_aktiv_next = 1'b0;
    end

    zaehler_next = PCSignal ? zaehler_reg + 1'b1 : zaehler_reg;
  end

  assign InterruptAktiv = irq_aktiv_reg;
  assign Befehlszaehler = zaehler_reg;

endmodule

// File: tb/tb_steuerung_v2.sv
// Directed bench for steuerung_v2: instruction flows, interrupts, halt,
// bus timeout, reset mid-instruction and retired-counter wrap.
module tb_steuerung_v2;

  localparam int DEK = 3;

  localparam logic [7:0] K_ALU   = 8'h00;
  localparam logic [7:0] K_LOAD  = 8'h01;
  localparam logic [7:0] K_STORE = 8'h02;
  localparam logic [7:0] K_UJMP  = 8'h08;
  localparam logic [7:0] K_BJMP  = 8'h10;
  localparam logic [7:0] K_BED   = 8'h20;
  localparam logic [7:0] K_RET   = 8'h40;
  localparam logic [7:0] K_HALT  = 8'h80;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       BefehlGeladen, DatenGeladen, DatenGespeichert, ALUFertig;
  logic       LoadBefehl, StoreBefehl, JALBefehl, UnbedingterSprungBefehl;
  logic       BedingterSprungBefehl, Bedingung, HaltBefehl, RueckkehrBefehl;
  logic [3:0] InterruptAnfrage, InterruptMaske;
  logic       LoadBefehlSignal, DekodierSignal, ALUStartSignal, RegisterSchreibSignal;
  logic       LoadDatenSignal, StoreDatenSignal, PCSignal, PCSprungSignal;
  logic       InterruptEintrittSignal, InterruptAktiv, Angehalten, BusFehler;
  logic [1:0] InterruptNummer;
  logic [3:0] Befehlszaehler;

  int checks = 0;
  int errors = 0;
  int n_dek = 0, n_pc = 0, n_ld = 0, n_st = 0;
  int s_dek, s_pc, s_ld, s_st;

  steuerung_v2 #(
    .DEKODIER_ZYKLEN (DEK),
    .TIMEOUT_ZYKLEN  (8),
    .IRQ_ANZAHL      (4),
    .ZAEHLER_BREITE  (4)
  ) dut (
    .Clock                   (Clock),
    .Reset                   (Reset),
    .BefehlGeladen           (BefehlGeladen),
    .DatenGeladen            (DatenGeladen),
    .DatenGespeichert        (DatenGespeichert),
    .ALUFertig               (ALUFertig),
    .LoadBefehl              (LoadBefehl),
    .StoreBefehl             (StoreBefehl),
    .JALBefehl               (JALBefehl),
    .UnbedingterSprungBefehl (UnbedingterSprungBefehl),
    .BedingterSprungBefehl   (BedingterSprungBefehl),
    .Bedingung               (Bedingung),
    .HaltBefehl              (HaltBefehl),
    .RueckkehrBefehl         (RueckkehrBefehl),
    .InterruptAnfrage        (InterruptAnfrage),
    .InterruptMaske          (InterruptMaske),
    .LoadBefehlSignal        (LoadBefehlSignal),
    .DekodierSignal          (DekodierSignal),
    .ALUStartSignal          (ALUStartSignal),
    .RegisterSchreibSignal   (RegisterSchreibSignal),
    .LoadDatenSignal         (LoadDatenSignal),
    .StoreDatenSignal        (StoreDatenSignal),
    .PCSignal                (PCSignal),
    .PCSprungSignal          (PCSprungSignal),
    .InterruptEintrittSignal (InterruptEintrittSignal),
    .InterruptAktiv          (InterruptAktiv),
    .Angehalten              (Angehalten),
    .BusFehler               (BusFehler),
    .InterruptNummer         (InterruptNummer),
    .Befehlszaehler          (Befehlszaehler)
  );

  always #5 Clock = ~Clock;

  // Mid-cycle pulse counters for multi-cycle strobes.
  always @(negedge Clock) begin
    if (DekodierSignal)   n_dek <= n_dek + 1;
    if (PCSignal)         n_pc  <= n_pc + 1;
    if (LoadDatenSignal)  n_ld  <= n_ld + 1;
    if (StoreDatenSignal) n_st  <= n_st + 1;
  end

  task automatic pruefe(input string tag, input logic [31:0] ist, input logic [31:0] soll);
    checks++;
    if (ist !== soll) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, ist, soll, $time);
    end
  endtask

  task automatic warte(input int n);
    if (n > 0) begin
      repeat (n) @(posedge Clock);
      #2;
    end
  endtask

  task automatic schnappschuss();
    s_dek = n_dek; s_pc = n_pc; s_ld = n_ld; s_st = n_st;
  endtask

  // Runs fetch, decode, ALU start and ALU; returns in the first writeback cycle.
  task automatic befehl(input logic [7:0] klasse, input int fetch_w, input int alu_w);
    $display("[%0t] befehl klasse=%02h fetch_w=%0d alu_w=%0d", $time, klasse, fetch_w, alu_w);
    pruefe("fetch_load", LoadBefehlSignal, 1);
    warte(fetch_w);
    BefehlGeladen = 1'b1;
    warte(1);
    BefehlGeladen = 1'b0;
    {HaltBefehl, RueckkehrBefehl, Bedingung, BedingterSprungBefehl,
     UnbedingterSprungBefehl, JALBefehl, StoreBefehl, LoadBefehl} = klasse;
    pruefe("decode_aktiv", DekodierSignal, 1);
    warte(DEK);
    pruefe("alustart", ALUStartSignal, 1);
    warte(1 + alu_w);
    ALUFertig = 1'b1;
    warte(1);
    ALUFertig = 1'b0;
  endtask

  initial begin
    Reset = 1'b0;
    {BefehlGeladen, DatenGeladen, DatenGespeichert, ALUFertig} = '0;
    {HaltBefehl, RueckkehrBefehl, Bedingung, BedingterSprungBefehl,
     UnbedingterSprungBefehl, JALBefehl, StoreBefehl, LoadBefehl} = '0;
    InterruptAnfrage = '0;
    InterruptMaske   = '0;

    warte(2);
    pruefe("rst_loadbefehl", LoadBefehlSignal, 1);
    pruefe("rst_dekodier", DekodierSignal, 0);
    pruefe("rst_zaehler", Befehlszaehler, 0);
    pruefe("rst_busfehler", BusFehler, 0);
    pruefe("rst_irq_aktiv", InterruptAktiv, 0);
    pruefe("rst_angehalten", Angehalten, 0);
    Reset = 1'b1;

    // ALU instruction; fetch handshake lands exactly on the timeout cycle
    $display("[%0t] transaktion: alu mit spaetem BefehlGeladen", $time);
    schnappschuss();
    befehl(K_ALU, 7, 2);
    pruefe("s1_kein_fehler", BusFehler, 0);
    pruefe("s1_wb_pc", PCSignal, 1);
    pruefe("s1_wb_regschreib", RegisterSchreibSignal, 1);
    pruefe("s1_zaehler_vor", Befehlszaehler, 0);
    warte(1);
    pruefe("s1_zaehler_nach", Befehlszaehler, 1);
    pruefe("s1_dek_zyklen", n_dek - s_dek, 3);
    pruefe("s1_pc_pulse", n_pc - s_pc, 1);

    // Load with DatenGeladen in the fifth wait cycle
    $display("[%0t] transaktion: load", $time);
    schnappschuss();
    befehl(K_LOAD, 1, 0);
    pruefe("s2_loaddaten", LoadDatenSignal, 1);
    pruefe("s2_kein_pc", PCSignal, 0);
    warte(4);
    DatenGeladen = 1'b1;
    warte(1);
    DatenGeladen = 1'b0;
    pruefe("s2_wb_regschreib", RegisterSchreibSignal, 1);
    pruefe("s2_wb_pc", PCSignal, 1);
    pruefe("s2_loaddaten_aus", LoadDatenSignal, 0);
    warte(1);
    pruefe("s2_ld_zyklen", n_ld - s_ld, 5);
    pruefe("s2_pc_pulse", n_pc - s_pc, 1);
    pruefe("s2_zaehler", Befehlszaehler, 2);

    // Store with pending interrupts, then nested requests held off
    $display("[%0t] transaktion: store mit interrupt", $time);
    schnappschuss();
    befehl(K_STORE, 0, 1);
    InterruptMaske   = 4'b1110;
    InterruptAnfrage = 4'b1010;
    #1;
    pruefe("s3_storedaten", StoreDatenSignal, 1);
    pruefe("s3_kein_pc", PCSignal, 0);
    warte(2);
    DatenGespeichert = 1'b1;
    #1;
    pruefe("s3_pc_bei_quit", PCSignal, 1);
    warte(1);
    DatenGespeichert = 1'b0;
    pruefe("s3_eintritt", InterruptEintrittSignal, 1);
    pruefe("s3_nummer", InterruptNummer, 1);
    pruefe("s3_aktiv_noch_0", InterruptAktiv, 0);
    pruefe("s3_zaehler", Befehlszaehler, 3);
    pruefe("s3_st_zyklen", n_st - s_st, 3);
    InterruptAnfrage = 4'b1000;
    warte(1);
    pruefe("s3_aktiv", InterruptAktiv, 1);
    befehl(K_ALU, 0, 0);
    warte(1);
    pruefe("s3_ignoriert_fetch", LoadBefehlSignal, 1);
    pruefe("s3_ignoriert_eintritt", InterruptEintrittSignal, 0);
    befehl(K_UJMP | K_RET, 0, 0);
    pruefe("s3_ret_pc", PCSignal, 1);
    pruefe("s3_ret_sprung", PCSprungSignal, 1);
    warte(1);
    pruefe("s3_ret_fetch", LoadBefehlSignal, 1);
    pruefe("s3_ret_aktiv_aus", InterruptAktiv, 0);
    befehl(K_ALU, 0, 0);
    warte(1);
    pruefe("s3_zweiter_eintritt", InterruptEintrittSignal, 1);
    pruefe("s3_zweite_nummer", InterruptNummer, 3);
    pruefe("s3_zaehler_6", Befehlszaehler, 6);
    InterruptAnfrage = 4'b0000;
    warte(1);

    // Halt, woken only by an enabled request
    $display("[%0t] transaktion: halt", $time);
    befehl(K_UJMP | K_RET, 0, 0);
    warte(1);
    pruefe("s4_aktiv_aus", InterruptAktiv, 0);
    pruefe("s4_zaehler_7", Befehlszaehler, 7);
    befehl(K_HALT | K_STORE, 0, 0);
    pruefe("s4_angehalten", Angehalten, 1);
    pruefe("s4_halt_vor_store", StoreDatenSignal, 0);
    pruefe("s4_kein_pc", PCSignal, 0);
    InterruptMaske   = 4'b0001;
    InterruptAnfrage = 4'b0010;
    warte(2);
    pruefe("s4_maskiert_bleibt", Angehalten, 1);
    InterruptAnfrage = 4'b0001;
    #1;
    pruefe("s4_pc_austritt", PCSignal, 1);
    warte(1);
    {HaltBefehl, StoreBefehl} = 2'b00;
    pruefe("s4_eintritt", InterruptEintrittSignal, 1);
    pruefe("s4_nummer", InterruptNummer, 0);
    pruefe("s4_zaehler_8", Befehlszaehler, 8);
    pruefe("s4_nicht_halt", Angehalten, 0);
    InterruptAnfrage = 4'b0000;
    warte(1);
    pruefe("s4_aktiv", InterruptAktiv, 1);

    // Asynchronous reset during a load
    $display("[%0t] transaktion: reset in WB_LOAD", $time);
    befehl(K_LOAD, 0, 0);
    warte(2);
    pruefe("s5_in_load", LoadDatenSignal, 1);
    Reset = 1'b0;
    #1;
    pruefe("s5_fetch", LoadBefehlSignal, 1);
    pruefe("s5_loaddaten_aus", LoadDatenSignal, 0);
    pruefe("s5_zaehler", Befehlszaehler, 0);
    pruefe("s5_aktiv", InterruptAktiv, 0);
    {LoadBefehl} = 1'b0;
    warte(1);
    Reset = 1'b1;

    // Fetch timeout to FAULT, held until reset
    $display("[%0t] transaktion: fetch timeout", $time);
    warte(7);
    pruefe("s6_vor_timeout", LoadBefehlSignal, 1);
    pruefe("s6_vor_busfehler", BusFehler, 0);
    warte(1);
    pruefe("s6_busfehler", BusFehler, 1);
    pruefe("s6_fetch_aus", LoadBefehlSignal, 0);
    schnappschuss();
    BefehlGeladen = 1'b1;
    warte(4);
    BefehlGeladen = 1'b0;
    pruefe("s6_busfehler_haelt", BusFehler, 1);
    pruefe("s6_kein_dekodier", DekodierSignal, 0);
    pruefe("s6_kein_pc", n_pc - s_pc, 0);
    Reset = 1'b0;
    #1;
    pruefe("s6_reset_busfehler", BusFehler, 0);
    pruefe("s6_reset_fetch", LoadBefehlSignal, 1);
    warte(1);
    Reset = 1'b1;

    // Counter wrap modulo 16, including both jump flavours
    $display("[%0t] transaktion: zaehler ueberlauf", $time);
    for (int i = 0; i < 16; i++) begin
      if (i == 0)      befehl(K_BJMP, 0, 0);
      else if (i == 1) befehl(K_BJMP | K_BED, 0, 0);
      else             befehl(K_ALU, 0, 0);
      pruefe("s7_pc", PCSignal, 1);
      if (i == 0) pruefe("s7_bjmp_ohne_bed", PCSprungSignal, 0);
      if (i == 1) pruefe("s7_bjmp_mit_bed", PCSprungSignal, 1);
      warte(1);
      if (i == 14) pruefe("s7_zaehler_15", Befehlszaehler, 15);
      if (i == 15) pruefe("s7_zaehler_wrap", Befehlszaehler, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/steuerung_v2.md
STEUERUNG_V2 -- requirements
Module: steuerung_v2

Interface
REQ-001 SHALL have parameter DEKODIER_ZYKLEN, default 2, number of decode cycles (legal 1..15).
REQ-002 SHALL have parameter TIMEOUT_ZYKLEN, default 64, bus-wait limit in cycles; 0 disables the timeout.
REQ-003 SHALL have parameter IRQ_ANZAHL, default 4, number of interrupt lines (legal 1..16).
REQ-004 SHALL have parameter ZAEHLER_BREITE, default 32, width of the retired-instruction counter.
REQ-005 Clock  input  1  the single clock; all state changes on its rising edge.
REQ-006 Reset  input  1  asynchronous, active-low reset.
REQ-007 BefehlGeladen, DatenGeladen, DatenGespeichert, ALUFertig  input  1 each  handshake completions.
REQ-008 LoadBefehl, StoreBefehl, JALBefehl, UnbedingterSprungBefehl, BedingterSprungBefehl, Bedingung  input  1 each  decoded instruction class and branch condition.
REQ-009 HaltBefehl, RueckkehrBefehl  input  1 each  halt instruction; return-from-interrupt jump.
REQ-010 InterruptAnfrage, InterruptMaske  input  IRQ_ANZAHL each  level requests; enable mask (1 = enabled).
REQ-011 LoadBefehlSignal, DekodierSignal, ALUStartSignal, RegisterSchreibSignal, LoadDatenSignal, StoreDatenSignal, PCSignal, PCSprungSignal  output  1 each  datapath controls.
REQ-012 InterruptEintrittSignal, InterruptAktiv, Angehalten, BusFehler  output  1 each  IRQ entry pulse, in-handler flag, halted, sticky bus fault.
REQ-013 InterruptNummer  output  $clog2(IRQ_ANZAHL) (min 1)  index of the interrupt being entered.
REQ-014 Befehlszaehler  output  ZAEHLER_BREITE  retired-instruction count.

Function
REQ-015 SHALL be a one-hot FSM with states FETCH, DECODE, ALUSTART, ALU, WB_JUMP, WB_STORE, WB_LOAD, WB_DEFAULT, IRQ_ENTRY, HALT and FAULT; any illegal encoding SHALL go to FETCH.
REQ-016 FETCH: LoadBefehlSignal=1; BefehlGeladen -> DECODE.
REQ-017 DECODE: DekodierSignal=1 for exactly DEKODIER_ZYKLEN cycles, then -> ALUSTART; ALUSTART (ALUStartSignal=1) -> ALU after one cycle.
REQ-018 ALU with ALUFertig=1 SHALL apply priority HaltBefehl -> HALT, jump (either kind) -> WB_JUMP, StoreBefehl -> WB_STORE, LoadBefehl -> WB_LOAD, else -> WB_DEFAULT; without ALUFertig it stays in ALU.
REQ-019 WB_STORE: StoreDatenSignal=1 until DatenGespeichert; WB_LOAD: LoadDatenSignal=1 until DatenGeladen, then -> WB_DEFAULT.
REQ-020 PCSignal SHALL pulse exactly once per instruction: in WB_JUMP, in WB_DEFAULT, in WB_STORE only on the DatenGespeichert cycle, and in HALT only on its exit cycle.
REQ-021 RegisterSchreibSignal = ((ALUSTART or ALU) and JALBefehl) or WB_DEFAULT; PCSprungSignal = UnbedingterSprungBefehl or (BedingterSprungBefehl and Bedingung), combinational.
REQ-022 At every instruction boundary (leaving WB_JUMP, WB_STORE or WB_DEFAULT), if InterruptAktiv=0 and (InterruptAnfrage & InterruptMaske) != 0, the next state SHALL be IRQ_ENTRY instead of FETCH.
REQ-023 IRQ_ENTRY lasts one cycle: InterruptEintrittSignal=1, InterruptNummer = lowest pending enabled index, InterruptAktiv set on exit; next state FETCH.
REQ-024 WB_JUMP with RueckkehrBefehl=1 SHALL clear InterruptAktiv on exit; the boundary check in that same cycle SHALL use the pre-clear value, so no interrupt is taken there.
REQ-025 HALT: Angehalten=1; leaves only to IRQ_ENTRY when an enabled request is pending, regardless of InterruptAktiv.
REQ-026 A wait counter SHALL clear on every state change and count cycles spent in FETCH, WB_LOAD or WB_STORE; at TIMEOUT_ZYKLEN waiting cycles without handshake -> FAULT.
REQ-027 FAULT: BusFehler=1, all other control outputs 0; exits only by reset.
REQ-028 Befehlszaehler SHALL increment on every PCSignal pulse and wrap modulo 2^ZAEHLER_BREITE.
REQ-029 When a handshake arrives in the same cycle the timeout expires, the handshake SHALL win.

Reset
REQ-030 Reset low SHALL immediately force state FETCH, wait counter 0, Befehlszaehler 0, InterruptAktiv 0 and BusFehler 0; outputs then decode from FETCH (only LoadBefehlSignal=1), including reset asserted mid-instruction.

Structure
REQ-031 State encodings and parameter defaults SHALL live in shared package steuerung_pkg.
REQ-032 The lowest-index pending-request selection SHALL be sub-module interrupt_prioritaet.

Verification
REQ-033 ALU instruction, DEKODIER_ZYKLEN=3, ALUFertig after 2 cycles -> DekodierSignal exactly 3 cycles, one PCSignal, Befehlszaehler 0->1.
REQ-034 Load with DatenGeladen after 5 cycles -> LoadDatenSignal 5 cycles, then WB_DEFAULT with RegisterSchreibSignal=1 and PCSignal=1 for one cycle.
REQ-035 InterruptAnfrage=4'b1010, Maske=4'b1110 during store -> after DatenGespeichert, IRQ_ENTRY with InterruptNummer=1; second request is ignored until RueckkehrBefehl.
REQ-036 TIMEOUT_ZYKLEN=8, BefehlGeladen never asserted -> FAULT after 8 cycles, BusFehler held until Reset low.
REQ-037 HaltBefehl -> Angehalten=1; request 0 enabled -> PCSignal pulse, IRQ_ENTRY, InterruptNummer=0.
REQ-038 Reset pulled low in WB_LOAD -> FETCH asynchronously, Befehlszaehler=0.
